// File: rtl/frame_req_arbiter.sv
// N-channel frame-buffer request arbiter: level req / pulse ack toward the channels,
// one committed grant per frame transfer, fixed or round-robin priority, ack timeout.
module frame_req_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int CH_W      = 1,
    parameter int ADDR_W    = 24,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic                     mem_req,
    input  logic                     mem_req_ack,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_finish,
    output logic [NUM_CH-1:0]        gnt_onehot,
    output logic [CH_W-1:0]          gnt_idx,
    output logic                     busy,
    output logic                     err_timeout,
    output logic [1:0]               dbg_state
);

    // Handshake: ch_req is a level held until the one-cycle ch_ack pulse; mem_req is a
    // level held until mem_req_ack is sampled high; mem_finish is a one-cycle pulse
    // honoured only while the transfer is in flight (BUSY).

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2,
        S_REL  = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TO_LAST = ~TIMEOUT_W'(1);

    state_t                r_state;
    logic [NUM_CH-1:0]     r_ch_ack;
    logic                  r_mem_req;
    logic [ADDR_W-1:0]     r_addr;
    logic [NUM_CH-1:0]     r_gnt;
    logic [CH_W-1:0]       r_gnt_idx;
    logic                  r_busy;
    logic                  r_err;
    logic [CH_W-1:0]       r_rr_ptr;
    logic [TIMEOUT_W-1:0]  r_cnt;

    logic [CH_W-1:0]       w_start;
    logic [CH_W:0]         w_pick;
    logic                  w_win_valid;
    logic [CH_W-1:0]       w_win_idx;
    logic [ADDR_W-1:0]     w_win_addr;

    // First requester at or after 'start', wrapping past NUM_CH-1; MSB flags a hit.
    function automatic logic [CH_W:0] pick(input logic [NUM_CH-1:0] req,
                                           input logic [CH_W-1:0]   start);
        logic [CH_W:0]     res;
        logic [NUM_CH-1:0] sh;
        int                k;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = int'(start) + i;
            if (k >= NUM_CH) k = k - NUM_CH;
            sh = req >> k;
            if (sh[0]) res = {1'b1, CH_W'(k)};
        end
        return res;
    endfunction

    function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] v);
        if (v == CH_W'(NUM_CH - 1)) return '0;
        return v + 1'b1;
    endfunction

    assign w_start     = (RR_MODE != 0) ? r_rr_ptr : '0;
    assign w_pick      = pick(ch_req, w_start);
    assign w_win_valid = w_pick[CH_W];
    assign w_win_idx   = w_pick[CH_W-1:0];

    always_comb begin
        w_win_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win_idx == CH_W'(i)) w_win_addr = ch_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ch_ack  <= '0;
            r_mem_req <= 1'b0;
            r_addr    <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_rr_ptr  <= '0;
            r_cnt     <= '0;
        end else begin
            r_ch_ack <= '0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_gnt     <= NUM_CH'(1) << w_win_idx;
                        r_gnt_idx <= w_win_idx;
                        r_addr    <= w_win_addr;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Ack wins over a timeout landing in the same cycle.
                    if (mem_req_ack) begin
                        r_mem_req <= 1'b0;
                        r_ch_ack  <= r_gnt;
                        r_state   <= S_BUSY;
                    end else if (r_cnt == TO_LAST) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                        if (RR_MODE != 0) r_rr_ptr <= next_idx(r_gnt_idx);
                    end
                end
                S_BUSY: begin
                    if (mem_finish) begin
                        r_gnt   <= '0;
                        r_state <= S_REL;
                    end
                end
                S_REL: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                    if (RR_MODE != 0) r_rr_ptr <= next_idx(r_gnt_idx);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ch_ack      = r_ch_ack;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_addr;
    assign gnt_onehot  = r_gnt;
    assign gnt_idx     = r_gnt_idx;
    assign busy        = r_busy;
    assign err_timeout = r_err;
    assign dbg_state   = r_state;

endmodule
